// File: rtl/benes_ctrl_sequencer_pkg.sv
// Shared types and constants for the Benes network control sequencer.
package benes_ctrl_sequencer_pkg;

  localparam int DEF_NUM_STAGES         = 9;
  localparam int DEF_SWITCHES_PER_STAGE = 16;

  // Switch settings for one stage (bit k = switch k, 1 = cross) and a full bank.
  typedef logic [DEF_SWITCHES_PER_STAGE-1:0] stage_set_t;
  typedef stage_set_t [DEF_NUM_STAGES-1:0]   bank_t;

  // Sequencer states: EMPTY -> LOAD -> FULL -> DRAIN -> EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } seq_state_e;

  // Width of a counter able to index n items (never narrower than one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/benes_ctrl_sequencer_if.sv
// Config stream, data-valid and switch-setting bundle of the control sequencer.
//
// Handshake: a config beat transfers on a rising edge where CFG_VALID and
// CFG_READY are both high. CFG_DATA must be stable while CFG_VALID is high;
// CFG_READY does not depend combinationally on CFG_VALID. CFG_COMMIT is a
// single-cycle pulse outside the valid/ready handshake.
interface benes_ctrl_sequencer_if #(
  parameter int NUM_STAGES         = 9,
  parameter int SWITCHES_PER_STAGE = 16
);

  logic                                          CFG_VALID;
  logic                                          CFG_READY;
  logic [SWITCHES_PER_STAGE-1:0]                 CFG_DATA;
  logic                                          CFG_COMMIT;
  logic                                          CFG_ERR;
  logic                                          I_VALID;
  logic [NUM_STAGES-1:0]                         O_STAGE_VALID;
  logic [NUM_STAGES-1:0][SWITCHES_PER_STAGE-1:0] O_SWITCH_SET;
  logic                                          O_BUSY;

  // Config source / data front end.
  modport master (
    output CFG_VALID, CFG_DATA, CFG_COMMIT, I_VALID,
    input  CFG_READY, CFG_ERR, O_STAGE_VALID, O_SWITCH_SET, O_BUSY
  );

  // The sequencer itself.
  modport slave (
    input  CFG_VALID, CFG_DATA, CFG_COMMIT, I_VALID,
    output CFG_READY, CFG_ERR, O_STAGE_VALID, O_SWITCH_SET, O_BUSY
  );

endinterface

// File: rtl/benes_ctrl_sequencer_skew_pipe.sv
// NUM_STAGES-deep 1-bit shift register exposing every tap. With COMB_HEAD set,
// tap 0 is the input itself and taps 1.. are registered copies; otherwise
// tap 0 is already one register behind the input.
module benes_skew_pipe #(
  parameter int NUM_STAGES = 9,
  parameter bit COMB_HEAD  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_d,
  output logic [NUM_STAGES-1:0] o_taps
);

  logic [NUM_STAGES-1:0] w_taps;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    if (s == 0 && COMB_HEAD) begin : g_comb
      assign w_taps[s] = i_d;
    end else begin : g_reg
      logic r_q;
      logic w_src;

      if (s == 0) begin : g_src_in
        assign w_src = i_d;
      end else begin : g_src_prev
        assign w_src = w_taps[s-1];
      end

      // Shift one stage per clock; reset empties the pipe.
      always_ff @(posedge clk) begin
        if (rst) r_q <= 1'b0;
        else     r_q <= w_src;
      end

      assign w_taps[s] = r_q;
    end
  end

  assign o_taps = w_taps;

endmodule

// File: rtl/benes_ctrl_sequencer.sv
// Control sequencer for the packed Benes network: loads per-stage switch
// settings into a shadow bank, swaps it to active on commit, and skews the
// bank select one stage per cycle so every data word sees a single setting.
module benes_ctrl_sequencer
  import benes_ctrl_sequencer_pkg::*;
#(
  parameter int NUM_STAGES         = DEF_NUM_STAGES,
  parameter int SWITCHES_PER_STAGE = DEF_SWITCHES_PER_STAGE
) (
  input  logic                         clk,
  input  logic                         rst,
  benes_ctrl_sequencer_if.slave        i_bus,
  output seq_state_e                   o_dbg_state
);

  localparam int               CNT_W      = cnt_w(NUM_STAGES);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'((NUM_STAGES > 1) ? NUM_STAGES - 2 : 0);

  // Two banks; the one not selected by r_active_bank is the shadow being loaded.
  logic [1:0][NUM_STAGES-1:0][SWITCHES_PER_STAGE-1:0] r_bank;

  seq_state_e       r_state;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] r_drain_cnt;
  logic             r_active_bank;
  logic             r_cfg_ready;
  logic             r_cfg_err;
  logic             r_busy;

  logic                                          w_cfg_accept;
  logic                                          w_commit_ok;
  logic                                          w_active_next;
  logic [NUM_STAGES-1:0]                         w_sel;
  logic [NUM_STAGES-1:0]                         w_stage_valid;
  logic [NUM_STAGES-1:0][SWITCHES_PER_STAGE-1:0] w_switch_set;

  assign w_cfg_accept  = i_bus.CFG_VALID && r_cfg_ready;
  assign w_commit_ok   = i_bus.CFG_COMMIT && (r_state == FULL);
  assign w_active_next = r_active_bank ^ w_commit_ok;

  // Sequencer FSM: load beats, wait for commit, hold off reloads while draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= EMPTY;
      r_beat_cnt    <= '0;
      r_drain_cnt   <= '0;
      r_active_bank <= 1'b0;
      r_cfg_ready   <= 1'b1;
      r_cfg_err     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      // Any commit outside FULL is rejected and flagged one cycle later.
      r_cfg_err <= i_bus.CFG_COMMIT && (r_state != FULL);
      case (r_state)
        EMPTY, LOAD: begin
          if (w_cfg_accept) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_state     <= FULL;
              r_beat_cnt  <= '0;
              r_cfg_ready <= 1'b0;
            end else begin
              r_state    <= LOAD;
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        FULL: begin
          if (i_bus.CFG_COMMIT) begin
            r_active_bank <= ~r_active_bank;
            r_drain_cnt   <= '0;
            if (NUM_STAGES > 1) begin
              r_state <= DRAIN;
              r_busy  <= 1'b1;
            end else begin
              r_state     <= EMPTY;
              r_cfg_ready <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // Stay until the last stage has switched over to the new bank.
          if (r_drain_cnt == LAST_DRAIN) begin
            r_state     <= EMPTY;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_cfg_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Accepted beat n lands in stage n of the shadow bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank <= '0;
    end else if (w_cfg_accept) begin
      r_bank[~r_active_bank][r_beat_cnt] <= i_bus.CFG_DATA;
    end
  end

  // Bank select follows the data wavefront: stage s switches s cycles after stage 0.
  benes_skew_pipe #(
    .NUM_STAGES (NUM_STAGES),
    .COMB_HEAD  (1'b0)
  ) u_sel_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_d    (w_active_next),
    .o_taps (w_sel)
  );

  // Word-valid tracking, stage 0 is the live input.
  benes_skew_pipe #(
    .NUM_STAGES (NUM_STAGES),
    .COMB_HEAD  (1'b1)
  ) u_valid_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_d    (i_bus.I_VALID),
    .o_taps (w_stage_valid)
  );

  // Each stage reads its own row from whichever bank its skewed select names.
  always_comb begin
    w_switch_set = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      w_switch_set[s] = r_bank[w_sel[s]][s];
    end
  end

  assign i_bus.CFG_READY     = r_cfg_ready;
  assign i_bus.CFG_ERR       = r_cfg_err;
  assign i_bus.O_BUSY        = r_busy;
  assign i_bus.O_STAGE_VALID = w_stage_valid;
  assign i_bus.O_SWITCH_SET  = w_switch_set;
  assign o_dbg_state         = r_state;

endmodule

// File: doc/benes_ctrl_sequencer.md
Name: benes_ctrl_sequencer

Overview:
Upstream control stage for the packed Benes network. It accepts switch-setting words over a valid/ready config stream and holds them in a double-buffered (shadow/active) bank. It drives the SWITCH_SET inputs of every packed_switch stage, with a per-stage skew equal to the one-cycle latency of each switch stage. A committed permutation therefore takes effect on a clean data boundary: no data word ever sees a mix of old and new settings.

Parameters:
NUM_STAGES, 9, switch stages in the network (2*log2(ports)-1)
SWITCHES_PER_STAGE, 16, 2x2 switches per stage (ports/2)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
CFG_VALID  input  1  config beat valid
CFG_READY  output  1  config beat accepted when CFG_VALID&&CFG_READY
CFG_DATA  input  SWITCHES_PER_STAGE  set bits for one stage; bit k = switch k (1 = cross)
CFG_COMMIT  input  1  single-cycle pulse: swap shadow to active
CFG_ERR  output  1  one-cycle pulse: illegal commit
I_VALID  input  1  data word entering stage 0 this cycle
O_STAGE_VALID  output  NUM_STAGES  bit s = valid word present at stage s input
O_SWITCH_SET  output  [NUM_STAGES-1:0][SWITCHES_PER_STAGE-1:0]  SWITCH_SET per stage/switch
O_BUSY  output  1  high while any stage still uses the previous bank

Behaviour:
- Reset (rst=1 at an edge): both banks all zero (pass-through), active_bank=0, sel_pipe all 0, beat_cnt=0, state EMPTY.
  - Outputs after reset: CFG_READY=1, CFG_ERR=0, O_STAGE_VALID=0, O_SWITCH_SET=0, O_BUSY=0.
  - Reset mid-load or mid-drain discards the shadow contents and any partial load.
- Config load: the accepted beat n (0-based) writes shadow[n] (stage n); beat_cnt increments.
- FSM states:
  - EMPTY: CFG_READY=1. First accepted beat -> LOAD. If NUM_STAGES==1, go directly -> FULL.
  - LOAD: CFG_READY=1. Accepted beat with beat_cnt==NUM_STAGES-1 -> FULL, beat_cnt cleared.
  - FULL: CFG_READY=0. CFG_COMMIT -> active_bank toggles at that edge -> DRAIN.
  - DRAIN: CFG_READY=0, O_BUSY=1 for exactly NUM_STAGES-1 cycles (drain counter), then -> EMPTY. Prevents overwriting a bank still used by downstream stages.
- CFG_COMMIT in EMPTY, LOAD or DRAIN: ignored (no bank swap, state unchanged); CFG_ERR pulses high the next cycle.
- Simultaneous CFG_COMMIT and the final beat in LOAD: the beat is accepted and the commit is an error. No swap happens.
- Skew: sel_pipe[0] <= active_bank (post-toggle); sel_pipe[s] <= sel_pipe[s-1].
  - O_SWITCH_SET[s] = bank[sel_pipe[s]][s], decoded combinationally from registers only.
  - A commit sampled at edge E makes stage s switch to the new bank after edge E+s.
  - Consequence: the first word with I_VALID in the cycle after E traverses every stage with new settings. A word entering before E uses old settings in every stage.
- Valid pipe: O_STAGE_VALID[0] = I_VALID (combinational); O_STAGE_VALID[s] <= O_STAGE_VALID[s-1]. Used for debug and scoreboard alignment only; switching does not depend on it.
- Back-to-back permutations: the minimum commit-to-commit spacing is (NUM_STAGES-1) + NUM_STAGES + 1 cycles.

Decomposition:
- benes_pkg holds:
  - typedef stage_set_t = logic [SWITCHES_PER_STAGE-1:0];
  - typedef bank_t = stage_set_t [NUM_STAGES-1:0];
  - enum seq_state_e {EMPTY, LOAD, FULL, DRAIN}.
- One natural sub-module, benes_skew_pipe: a parameterised NUM_STAGES-deep 1-bit shift register with tap outputs. It is instantiated twice, once for sel_pipe and once for the valid pipe.

Test Plan:
Bench runs with NUM_STAGES=3, SWITCHES_PER_STAGE=4.
- Reset, hold for 5 cycles -> O_SWITCH_SET=0, CFG_READY=1, O_BUSY=0, CFG_ERR=0.
- Load beats 0x1,0x2,0x4, then commit at edge E -> CFG_READY=0 after the third beat. O_SWITCH_SET[0]=0x1 after E, [1]=0x2 after E+1, [2]=0x4 after E+2.
- Skew check: I_VALID=1 in cycles E-1 and E+1 -> the first word sees all-zero sets in every stage, the second sees 0x1/0x2/0x4 in every stage.
- Commit in LOAD after 2 beats -> CFG_ERR=1 for one cycle, no change to O_SWITCH_SET, the third beat is still accepted.
- After a commit, O_BUSY=1 and CFG_READY=0 for exactly 2 cycles. A CFG_VALID held high is accepted only in the third cycle. A second permutation 0xF,0x0,0xA then applies with the same skew.
- rst asserted during DRAIN -> next cycle all sets 0, state EMPTY, the previously active permutation is lost.
